wb_slave_mux: RTL and testbench
===============================

// Module: wb_slave_mux
// PURPOSE
//  Parametrised Wishbone fan-out for the user area: decodes region REGION of the caravel
//  WB bus into N_SLV slave ports by address field, registers the transaction, returns ack/data.
//  Adds per-transaction timeout, error response for unmapped or hung slaves,
//  cycle-abort handling, and masked, registered IRQ aggregation. Sits between
//  the wrapper's WB pins and the user slaves (user_proj_example, uart, ...).
// PARAMETERS
//  N_SLV     4             number of slave ports, 1..2**SEL_W
//  SEL_LO    24            LSB of the slave-index field in wbs_adr_i
//  SEL_W     2             width of the slave-index field
//  REGION    4'h3          wbs_adr_i[31:28] value claimed by this block
//  TIMEOUT   255           max cycles waiting for a slave ack, 1..65535
//  ERR_DATA  32'hDEAD_BEEF read data returned on error
//  IRQ_EN    {N_SLV{1'b1}} per-slave IRQ enable mask
// PORTS
//  wb_clk_i    in   1         clock
//  wb_rst_i    in   1         reset; asynchronous, active-high
//  wbs_cyc_i   in   1         master cycle
//  wbs_stb_i   in   1         master strobe
//  wbs_we_i    in   1         write enable
//  wbs_sel_i   in   4         byte selects
//  wbs_adr_i   in   32        address
//  wbs_dat_i   in   32        write data
//  wbs_ack_o   out  1         ack to master (1-cycle pulse)
//  wbs_dat_o   out  32        read data, valid with ack
//  s_cyc_o     out  1         cycle to slaves (high while a slave is strobed)
//  s_stb_o     out  N_SLV     one-hot strobe to selected slave
//  s_we_o      out  1         latched we
//  s_sel_o     out  4         latched sel
//  s_adr_o     out  32        latched address (broadcast)
//  s_dat_o     out  32        latched write data (broadcast)
//  s_ack_i     in   N_SLV     slave acks
//  s_dat_i     in   32*N_SLV  slave read data, slave i at [32*i+:32]
//  s_irq_i     in   3*N_SLV   slave irqs, slave i at [3*i+:3]
//  user_irq    out  3         aggregated irq
//  err_o       out  1         1-cycle pulse on every error response
//  err_cnt_o   out  8         saturating error count
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; latches, timer, err_cnt cleared. Reset mid-
//   transaction abandons it silently (no ack); any late slave ack is ignored.
//  hit = cyc & stb & adr[31:28]==REGION; idx = adr[SEL_LO+:SEL_W]. Non-hit: no ack.
//  FSM IDLE: on hit latch we/sel/adr/dat/idx; timer<=0.
//   idx<N_SLV -> WAIT, s_stb_o[idx]=1 and s_cyc_o=1 next cycle (registered).
//   idx>=N_SLV -> RESP with dat=ERR_DATA, err (no slave strobed).
//  WAIT: hold s_* stable; timer++ each cycle.
//   s_ack_i[idx]=1 -> latch s_dat_i[idx] (writes: latch 0), drop s_stb/s_cyc, RESP.
//   acks from other slaves ignored.
//   timer==TIMEOUT-1 with no ack -> drop s_stb/s_cyc, RESP with ERR_DATA, err.
//   ack and timeout same cycle -> ack wins, no error.
//   wbs_cyc_i low -> abort: drop s_stb/s_cyc, IDLE, no ack, no error.
//  RESP: wbs_ack_o=1, wbs_dat_o=response for exactly one cycle, then IDLE.
//   wbs_dat_o=0 outside ack cycle. IDLE ignores stb in the cycle after ack.
//  Latency: hit at cycle 0 -> s_stb at 1; slave ack at k -> wbs_ack_o at k+1.
//   Unmapped: wbs_ack_o at cycle 1. Timeout: wbs_ack_o at cycle TIMEOUT+1.
//  err_o pulses in the RESP cycle of an error. err_cnt_o +1 per error, saturates 255.
//  user_irq registered: OR over i of (s_irq_i[3*i+:3] & {3{IRQ_EN[i]}}); 1-cycle lag.
//  One outstanding transaction; no pipelining; no retry.
// TESTING
//  Read slave 1 (adr 0x3100_0010), slave acks 2 cycles after stb, data 0x1234_5678
//   -> s_stb_o=4'b0010 at cycle 1; wbs_ack_o one cycle, data 0x1234_5678, at cycle 4.
//  Write slave 0 adr 0x3000_0000 dat 0xA5A5_A5A5 sel 4'hF
//   -> s_adr/s_dat/s_sel/s_we latched; single wbs_ack_o; wbs_dat_o=0.
//  N_SLV=3, read adr 0x3300_0000 -> no s_stb; ack at cycle 1; dat 0xDEAD_BEEF;
//   err_o pulse; err_cnt_o=1.
//  Slave 2 never acks, TIMEOUT=8 -> s_stb_o[2] high cycles 1..8; ack at cycle 9
//   with 0xDEAD_BEEF; later stray s_ack_i[2] ignored.
//  Drop wbs_cyc_i in WAIT, or assert wb_rst_i mid-WAIT -> s_stb_o=0 next cycle /
//   immediately; no wbs_ack_o; err_cnt_o unchanged (reset: 0).
//  IRQ_EN=4'b1011, s_irq_i slave2=3'b100, slave3=3'b001 -> user_irq=3'b001 one
//   cycle later; adr 0x2100_0000 -> no strobe, no ack.

Source files
------------

// File: rtl/wb_slave_mux.sv
// wb_slave_mux
//   Wishbone fan-out for the user area. Claims one 256 MB region of the
//   caravel WB bus (adr[31:28] == REGION), splits it into N_SLV slave ports
//   by the address field adr[SEL_LO +: SEL_W], and runs one registered
//   transaction at a time. The block answers with an error response when
//   the index is unmapped or the slave never acks. A dropped master cycle
//   aborts silently. It also aggregates masked slave IRQs into user_irq.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_*_i / wbs_*_o         upstream Wishbone slave interface (master side)
//   s_cyc_o, s_stb_o[N_SLV]   cycle and one-hot strobe to the selected slave
//   s_we/sel/adr/dat_o        latched request, broadcast to every slave
//   s_ack_i[N_SLV]            slave acks
//   s_dat_i[32*N_SLV]         slave read data, slave i at [32*i +: 32]
//   s_irq_i[3*N_SLV]          slave irqs, slave i at [3*i +: 3]
//   user_irq[3]               registered, masked OR of slave irqs
//   err_o, err_cnt_o[8]       error pulse (during the response) and saturating count
module wb_slave_mux #(
  parameter int               N_SLV    = 4,
  parameter int               SEL_LO   = 24,
  parameter int               SEL_W    = 2,
  parameter logic [3:0]       REGION   = 4'h3,
  parameter int               TIMEOUT  = 255,
  parameter logic [31:0]      ERR_DATA = 32'hDEAD_BEEF,
  parameter logic [N_SLV-1:0] IRQ_EN   = {N_SLV{1'b1}}
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic                 s_cyc_o,
  output logic [N_SLV-1:0]     s_stb_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [N_SLV-1:0]     s_ack_i,
  input  logic [32*N_SLV-1:0]  s_dat_i,
  input  logic [3*N_SLV-1:0]   s_irq_i,
  output logic [2:0]           user_irq,
  output logic                 err_o,
  output logic [7:0]           err_cnt_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Timer value in the last WAIT cycle before the timeout response.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        wdat_q, wdat_d;
  logic [N_SLV-1:0]   stb_q, stb_d;
  logic               cyc_q, cyc_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdat_q, rdat_d;
  logic               err_q, err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic [2:0]         irq_q, irq_d;
  logic               post_ack_q, post_ack_d;

  logic               hit;
  logic [SEL_W-1:0]   adr_idx;
  logic               idx_ok;
  logic [N_SLV-1:0]   stb_dec;
  logic               slv_ack;
  logic [31:0]        slv_dat;
  logic               err_evt;

  logic [31:0]        dat_terms [N_SLV];
  logic [2:0]         irq_terms [N_SLV];

  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == REGION);
  assign adr_idx = wbs_adr_i[SEL_LO +: SEL_W];
  assign idx_ok  = (32'(adr_idx) < N_SLV);

  // Per-slave decode, read-data gating and irq masking. stb_q is one-hot on
  // the selected slave, so it doubles as the ack/data select in WAIT and
  // automatically ignores acks from any other slave.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLV; gi++) begin : g_slv
      assign stb_dec[gi]   = (adr_idx == SEL_W'(gi));
      assign dat_terms[gi] = s_dat_i[32*gi +: 32] & {32{stb_q[gi]}};
      assign irq_terms[gi] = s_irq_i[3*gi +: 3] & {3{IRQ_EN[gi]}};
    end
  endgenerate

  assign slv_ack = |(s_ack_i & stb_q);

  always_comb begin
    slv_dat = '0;
    irq_d   = '0;
    for (int i = 0; i < N_SLV; i++) begin
      slv_dat = slv_dat | dat_terms[i];
      irq_d   = irq_d | irq_terms[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    stb_d      = stb_q;
    cyc_d      = cyc_q;
    ack_d      = 1'b0;
    rdat_d     = '0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    post_ack_d = 1'b0;
    err_evt    = 1'b0;

    case (state_q)
      IDLE: begin
        // The cycle right after an ack still carries the master's old strobe,
        // so a hit there is not treated as a new request.
        if (hit && !post_ack_q) begin
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          adr_d   = wbs_adr_i;
          wdat_d  = wbs_dat_i;
          timer_d = '0;
          if (idx_ok) begin
            state_d = WAIT;
            stb_d   = stb_dec;
            cyc_d   = 1'b1;
          end else begin
            state_d = RESP;
            ack_d   = 1'b1;
            rdat_d  = ERR_DATA;
            err_evt = 1'b1;
          end
        end
      end

      WAIT: begin
        timer_d = timer_q + 16'd1;
        if (!wbs_cyc_i) begin
          // Master gave up: release the slave and return without a response.
          state_d = IDLE;
          stb_d   = '0;
          cyc_d   = 1'b0;
        end else if (slv_ack) begin
          // Checked before the timeout so an ack in the last cycle still wins.
          state_d = RESP;
          stb_d   = '0;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          rdat_d  = we_q ? 32'd0 : slv_dat;
        end else if (timer_q == TIMER_LAST) begin
          state_d = RESP;
          stb_d   = '0;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          rdat_d  = ERR_DATA;
          err_evt = 1'b1;
        end
      end

      RESP: begin
        state_d    = IDLE;
        post_ack_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        stb_d   = '0;
        cyc_d   = 1'b0;
      end
    endcase

    if (err_evt) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      stb_q      <= '0;
      cyc_q      <= 1'b0;
      ack_q      <= 1'b0;
      rdat_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      irq_q      <= '0;
      post_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      stb_q      <= stb_d;
      cyc_q      <= cyc_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      irq_q      <= irq_d;
      post_ack_q <= post_ack_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign s_cyc_o   = cyc_q;
  assign s_stb_o   = stb_q;
  assign s_we_o    = we_q;
  assign s_sel_o   = sel_q;
  assign s_adr_o   = adr_q;
  assign s_dat_o   = wdat_q;
  assign user_irq  = irq_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Bench for wb_slave_mux: four slave ports, 3-bit index field (indices 4..7
// unmapped), TIMEOUT=8, IRQ_EN=4'b1011. Cycle 0 is the cycle in which the
// request is presented; inputs change 1 ns after a rising edge and outputs
// are sampled on the falling edge.
module tb_wb_slave_mux;

  localparam logic [3:0]  IRQ_EN_TB = 4'b1011;
  localparam int          TMO       = 8;
  localparam logic [31:0] ERRD      = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         ack;
  logic [31:0]  rdat;
  logic         s_cyc;
  logic [3:0]   s_stb;
  logic         s_we;
  logic [3:0]   s_sel;
  logic [31:0]  s_adr, s_dat;
  logic [3:0]   s_ack;
  logic [127:0] s_dat_in;
  logic [11:0]  s_irq;
  logic [2:0]   uirq;
  logic         err;
  logic [7:0]   err_cnt;

  int total = 0;
  int bad   = 0;
  int model_err_cnt = 0;

  always #5 clk = ~clk;

  wb_slave_mux #(
    .N_SLV(4), .SEL_LO(24), .SEL_W(3), .REGION(4'h3),
    .TIMEOUT(TMO), .ERR_DATA(ERRD), .IRQ_EN(IRQ_EN_TB)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat),
    .s_ack_i(s_ack), .s_dat_i(s_dat_in), .s_irq_i(s_irq),
    .user_irq(uirq), .err_o(err), .err_cnt_o(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  function automatic void note_error();
    if (model_err_cnt < 255) model_err_cnt++;
  endfunction

  // One master transaction. ack_at is the cycle in which the addressed slave
  // raises its ack (values beyond the timeout mean it never answers in time).
  // A different slave also acks in cycle 1 to show foreign acks are ignored.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] sl, input int ack_at, input logic [31:0] slv_rd,
                         input logic linger, input string tag);
    int          idx;
    bit          mapped;
    int          exp_ack_cyc;
    logic [31:0] exp_dat;
    bit          exp_err;
    int          ack_cyc;
    logic [31:0] got_dat;
    logic        got_err;
    int          stb_cnt;
    bit          stb_bad, lat_bad, leak;

    idx    = int'(a[26:24]);
    mapped = (idx < 4);
    if (!mapped) begin
      exp_ack_cyc = 1; exp_dat = ERRD; exp_err = 1'b1;
    end else if (ack_at >= 1 && ack_at <= TMO) begin
      exp_ack_cyc = ack_at + 1; exp_dat = w ? 32'd0 : slv_rd; exp_err = 1'b0;
    end else begin
      exp_ack_cyc = TMO + 1; exp_dat = ERRD; exp_err = 1'b1;
    end
    if (exp_err) note_error();

    s_dat_in = {$urandom, $urandom, $urandom, $urandom};
    if (mapped) s_dat_in[32*idx +: 32] = slv_rd;

    ack_cyc = -1; got_dat = '0; got_err = 1'b0;
    stb_cnt = 0; stb_bad = 1'b0; lat_bad = 1'b0; leak = 1'b0;

    drive_point();
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = wd; sel = sl;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) drive_point();
      s_ack = '0;
      if (mapped && c == ack_at) s_ack[idx] = 1'b1;
      if (mapped && c == 1 && ack_at != 1) s_ack[(idx + 1) % 4] = 1'b1;
      @(negedge clk);
      if (s_stb != 4'b0) begin
        stb_cnt++;
        if (s_stb !== (4'b0001 << idx) || s_cyc !== 1'b1) stb_bad = 1'b1;
        if (s_adr !== a || s_dat !== wd || s_sel !== sl || s_we !== w) lat_bad = 1'b1;
      end
      if (ack === 1'b1) begin
        ack_cyc = c; got_dat = rdat; got_err = err;
        break;
      end else if (rdat !== 32'd0 || err !== 1'b0) begin
        leak = 1'b1;
      end
    end

    drive_point();
    s_ack = '0;
    if (!linger) begin cyc = 1'b0; stb = 1'b0; end
    @(negedge clk);
    check({tag, " ack_cycle"}, 32'(ack_cyc), 32'(exp_ack_cyc));
    check({tag, " rdata"}, got_dat, exp_dat);
    check({tag, " err_pulse"}, 32'(got_err), 32'(exp_err));
    check({tag, " stb_cycles"}, 32'(stb_cnt), mapped ? 32'(exp_ack_cyc - 1) : 32'd0);
    check({tag, " stb_onehot_bad"}, 32'(stb_bad), 32'd0);
    check({tag, " latch_bad"}, 32'(lat_bad), 32'd0);
    check({tag, " idle_output_leak"}, 32'(leak), 32'd0);
    check({tag, " ack_after"}, {31'd0, ack}, 32'd0);
    check({tag, " dat_after"}, rdat, 32'd0);
    check({tag, " err_after"}, {31'd0, err}, 32'd0);
    check({tag, " err_cnt"}, {24'd0, err_cnt}, 32'(model_err_cnt));
    if (linger) begin
      drive_point();
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check({tag, " linger_no_restrobe"}, {28'd0, s_stb}, 32'd0);
      check({tag, " linger_no_ack"}, {31'd0, ack}, 32'd0);
    end
    $display("txn %s adr=%h we=%0d ack_at=%0d -> ack_cycle=%0d data=%h err=%0d err_cnt=%0d",
             tag, a, w, ack_at, ack_cyc, got_dat, got_err, err_cnt);
  endtask

  // Hold the bus idle for n cycles and report how many acks/strobes appeared.
  task automatic quiet_cycles(input int n, input string tag);
    int acks, stbs;
    acks = 0; stbs = 0;
    for (int c = 0; c < n; c++) begin
      drive_point();
      s_ack = '0;
      @(negedge clk);
      if (ack === 1'b1) acks++;
      if (s_stb != 4'b0) stbs++;
    end
    check({tag, " acks"}, 32'(acks), 32'd0);
    check({tag, " strobes"}, 32'(stbs), 32'd0);
  endtask

  function automatic logic [2:0] irq_model(input logic [11:0] v);
    logic [2:0] e;
    e = 3'b000;
    for (int i = 0; i < 4; i++) if (IRQ_EN_TB[i]) e = e | v[3*i +: 3];
    return e;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  irq_exp;
    logic [31:0] ra;
    int          hits;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    s_ack = '0; s_dat_in = '0; s_irq = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ack", {31'd0, ack}, 32'd0);
    check("reset dat", rdat, 32'd0);
    check("reset s_cyc", {31'd0, s_cyc}, 32'd0);
    check("reset s_stb", {28'd0, s_stb}, 32'd0);
    check("reset s_adr", s_adr, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset err_cnt", {24'd0, err_cnt}, 32'd0);
    check("reset user_irq", {29'd0, uirq}, 32'd0);
    drive_point();
    rst = 1'b0;

    // Directed transactions.
    run_txn(32'h3100_0010, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b1, "read_s1");
    run_txn(32'h3000_0000, 1'b1, 32'hA5A5_A5A5, 4'hF, 1, 32'h5555_AAAA, 1'b0, "write_s0");
    run_txn(32'h3400_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0, 1'b0, "unmapped");
    run_txn(32'h3200_0000, 1'b0, 32'h0, 4'h3, 1000, 32'h1111_2222, 1'b0, "timeout_s2");

    // Stray late ack from slave 2 must not produce a response.
    drive_point();
    s_ack = 4'b0100;
    @(negedge clk);
    quiet_cycles(3, "stray_ack");
    check("stray_ack err_cnt", {24'd0, err_cnt}, 32'(model_err_cnt));

    run_txn(32'h3300_0040, 1'b0, 32'h0, 4'hC, TMO, 32'hCAFE_F00D, 1'b0, "ack_at_timeout");
    run_txn(32'h3200_0004, 1'b1, 32'h0BAD_F00D, 4'h1, TMO + 1, 32'h0, 1'b0, "ack_just_late");

    // Abort: master drops cyc while the slave is strobed.
    drive_point();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3100_0000; sel = 4'hF;
    drive_point();
    @(negedge clk);
    check("abort stb_cycle1", {28'd0, s_stb}, 32'h2);
    drive_point();
    cyc = 1'b0; stb = 1'b0;
    drive_point();
    @(negedge clk);
    check("abort stb_dropped", {28'd0, s_stb}, 32'd0);
    check("abort cyc_dropped", {31'd0, s_cyc}, 32'd0);
    s_ack = 4'b0010;
    quiet_cycles(4, "abort");
    check("abort err_cnt", {24'd0, err_cnt}, 32'(model_err_cnt));

    // Address outside the claimed region.
    drive_point();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h2100_0000;
    quiet_cycles(5, "non_region");
    cyc = 1'b0; stb = 1'b0;

    // IRQ aggregation: slave2 is masked off, slave3 passes.
    drive_point();
    s_irq = {3'b001, 3'b100, 3'b000, 3'b000};
    @(negedge clk);
    check("irq lag", {29'd0, uirq}, 32'd0);
    drive_point();
    @(negedge clk);
    check("irq masked", {29'd0, uirq}, 32'h1);
    irq_exp = 3'b001;
    for (int i = 0; i < 8; i++) begin
      drive_point();
      s_irq = 12'($urandom);
      @(negedge clk);
      check($sformatf("irq_hold%0d", i), {29'd0, uirq}, {29'd0, irq_exp});
      irq_exp = irq_model(s_irq);
      drive_point();
      @(negedge clk);
      check($sformatf("irq_rand%0d", i), {29'd0, uirq}, {29'd0, irq_exp});
      $display("irq s_irq=%h -> user_irq=%b", s_irq, uirq);
    end

    // Randomized transactions against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = {4'h3, 28'($urandom)};
      run_txn(ra, 1'($urandom), $urandom, 4'($urandom), 1 + int'($urandom_range(0, 10)),
              $urandom, 1'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a WAIT.
    drive_point();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3300_0000;
    drive_point();
    @(negedge clk);
    check("rst_mid stb_before", {28'd0, s_stb}, 32'h8);
    drive_point();
    rst = 1'b1;
    #1;
    check("rst_mid stb_now", {28'd0, s_stb}, 32'd0);
    check("rst_mid cyc_now", {31'd0, s_cyc}, 32'd0);
    check("rst_mid err_cnt", {24'd0, err_cnt}, 32'd0);
    model_err_cnt = 0;
    cyc = 1'b0; stb = 1'b0;
    drive_point();
    rst = 1'b0;
    s_ack = 4'b1000;
    quiet_cycles(4, "rst_mid");

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      run_txn({4'h3, 1'b0, 3'(4 + (i % 4)), 24'($urandom)}, 1'b0, 32'h0, 4'hF, 1, 32'h0,
              1'b0, $sformatf("sat%0d", i));
    end
    check("err_cnt saturated", {24'd0, err_cnt}, 32'd255);

    // Post-saturation mapped read still works.
    hits = 0;
    run_txn(32'h3000_0100, 1'b0, 32'h0, 4'hF, 2, 32'h7777_0001, 1'b0, "after_sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
